// File: rtl/ksa_pkg.sv
// ksa_pkg: shared types and defaults for the KSA replay buffer.
//   operand_t  : one buffered operand triple {a, b, cin}
//   rb_state_e : replay-buffer control states
//   KSA_*      : default DATA_W / DEPTH / MAX_RETRY
// The operand_t width comes from KSA_DATA_W. A top-level DATA_W override
// therefore has to be matched by changing KSA_DATA_W here.
package ksa_pkg;

  localparam int unsigned KSA_DATA_W    = 8;
  localparam int unsigned KSA_DEPTH     = 8;
  localparam int unsigned KSA_MAX_RETRY = 3;

  typedef struct packed {
    logic [KSA_DATA_W-1:0] a;
    logic [KSA_DATA_W-1:0] b;
    logic                  cin;
  } operand_t;

  typedef enum logic [1:0] {
    RB_RUN    = 2'd0,
    RB_DRAIN  = 2'd1,
    RB_REWIND = 2'd2
  } rb_state_e;

  // Plain-vector state encodings, kept compatible with older tooling
  localparam logic [1:0] ST_RUN    = RB_RUN;
  localparam logic [1:0] ST_DRAIN  = RB_DRAIN;
  localparam logic [1:0] ST_REWIND = RB_REWIND;

endpackage

// File: rtl/ksa_rb_mem.sv
// ksa_rb_mem: DEPTH x operand_t storage for the replay buffer.
//   clk         : clock
//   we          : write enable
//   waddr/wdata : write port
//   raddr/rdata : asynchronous read port
// The storage has no reset. Validity is tracked only by the pointers in
// the parent.
module ksa_rb_mem
  import ksa_pkg::*;
#(
  parameter int unsigned DEPTH = KSA_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  operand_t                 wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output operand_t                 rdata
);

  operand_t mem [DEPTH];

  // Single write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ksa_replay_buffer.sv
// ksa_replay_buffer: upstream operand buffer for the shadow-clocked KSA adder.
// It keeps every operand until its result is accepted clean downstream.
// When the adder reports a mismatch, the buffer kills the younger in-flight
// results and re-issues from the failing entry.
//   clk, rst_n            : clock; asynchronous reset, active HIGH despite the name
//   s_a/s_b/s_cin/s_vld   : source operands in; s_rdy = space available
//   m_a/m_b/m_cin/m_vld   : operands to the adder; m_rdy = adder accepts
//   res_vld/res_rdy       : adder result handshake (observed here)
//   res_mismatch          : shadow-latch mismatch, qualified by res_vld
//   res_kill              : current result is stale and must be discarded
//   replay                : one-cycle pulse when the issue pointer rewinds
//   err                   : sticky; set when an entry is force-committed
//   occupancy             : number of uncommitted entries
// Optional feature macro KSA_REPLAY_STATS_EN adds replay_total/kill_total,
// which are saturating 16-bit event counters.
module ksa_replay_buffer
  import ksa_pkg::*;
#(
  parameter int unsigned DATA_W    = KSA_DATA_W,
  parameter int unsigned DEPTH     = KSA_DEPTH,
  parameter int unsigned MAX_RETRY = KSA_MAX_RETRY
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DATA_W-1:0]      s_a,
  input  logic [DATA_W-1:0]      s_b,
  input  logic                   s_cin,
  input  logic                   s_vld,
  output logic                   s_rdy,
  output logic [DATA_W-1:0]      m_a,
  output logic [DATA_W-1:0]      m_b,
  output logic                   m_cin,
  output logic                   m_vld,
  input  logic                   m_rdy,
  input  logic                   res_vld,
  input  logic                   res_rdy,
  input  logic                   res_mismatch,
  output logic                   res_kill,
  output logic                   replay,
  output logic                   err,
  output logic [$clog2(DEPTH):0] occupancy
`ifdef KSA_REPLAY_STATS_EN
  ,
  output logic [15:0]            replay_total,
  output logic [15:0]            kill_total
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] iss_q, iss_d;
  logic [PW-1:0] cmt_q, cmt_d;
  logic [PW-1:0] drain_q, drain_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [1:0]    state_q, state_d;
  logic          err_q, err_d;

  logic     wr_fire, iss_fire, res_fire, retry_max;
  operand_t wdata, rdata;

  // Handshakes. A result that arrives with nothing outstanding is ignored.
  assign wr_fire   = s_vld & s_rdy;
  assign iss_fire  = m_vld & m_rdy;
  assign res_fire  = res_vld & res_rdy & (iss_q != cmt_q);
  assign retry_max = (retry_q == RW'(MAX_RETRY));

  assign occupancy = wr_q - cmt_q;
  assign s_rdy     = ((wr_q - cmt_q) != PW'(DEPTH));
  assign m_vld     = (state_q == ST_RUN) && (iss_q != wr_q);
  assign replay    = (state_q == ST_REWIND);
  assign err       = err_q;

  assign wdata = '{a: s_a, b: s_b, cin: s_cin};
  assign m_a   = rdata.a;
  assign m_b   = rdata.b;
  assign m_cin = rdata.cin;

  ksa_rb_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_fire),
    .waddr (wr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (iss_q[AW-1:0]),
    .rdata (rdata)
  );

  // Stale-result marking. A mismatch at the retry limit is committed, not killed.
  always_comb begin
    res_kill = 1'b0;
    case (state_q)
      ST_RUN:  res_kill = res_vld & res_mismatch & ~retry_max;
      default: res_kill = res_vld;
    endcase
  end

  // Next-state and pointer update
  always_comb begin
    state_d = state_q;
    wr_d    = wr_q + PW'(wr_fire);
    iss_d   = iss_q + PW'(iss_fire);
    cmt_d   = cmt_q;
    drain_d = drain_q;
    retry_d = retry_q;
    err_d   = err_q;
    case (state_q)
      ST_RUN: begin
        if (res_fire) begin
          if (!res_mismatch || retry_max) begin
            cmt_d   = cmt_q + PW'(1);
            retry_d = '0;
            if (res_mismatch) begin
              err_d = 1'b1;
            end
          end else begin
            retry_d = retry_q + RW'(1);
            // Count the younger results still to come back. This includes
            // an issue accepted on this same edge.
            drain_d = iss_d - cmt_q - PW'(1);
            state_d = (drain_d == '0) ? ST_REWIND : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (res_fire) begin
          drain_d = drain_q - PW'(1);
          if (drain_q == PW'(1)) begin
            state_d = ST_REWIND;
          end
        end
      end
      ST_REWIND: begin
        iss_d   = cmt_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q <= ST_RUN;
      wr_q    <= '0;
      iss_q   <= '0;
      cmt_q   <= '0;
      drain_q <= '0;
      retry_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      iss_q   <= iss_d;
      cmt_q   <= cmt_d;
      drain_q <= drain_d;
      retry_q <= retry_d;
      err_q   <= err_d;
    end
  end

`ifdef KSA_REPLAY_STATS_EN
  // Saturating event counters
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      replay_total <= '0;
      kill_total   <= '0;
    end else begin
      if (replay && (replay_total != 16'hFFFF)) begin
        replay_total <= replay_total + 16'd1;
      end
      if (res_kill && res_vld && res_rdy && (kill_total != 16'hFFFF)) begin
        kill_total <= kill_total + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ksa_replay_buffer.sv
// tb_ksa_replay_buffer: directed and randomized checks of ksa_replay_buffer.
// The bench acts as the source, as a one-cycle-latency adder and as the
// downstream sink. Committed (non-killed) results must come back in source
// order. rst_n is active high.
module tb_ksa_replay_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_a, s_b, m_a, m_b;
  logic       s_cin, s_vld, s_rdy, m_cin, m_vld, m_rdy;
  logic       res_vld, res_rdy, res_mismatch, res_kill, replay, err;
  logic [3:0] occupancy;
`ifdef KSA_REPLAY_STATS_EN
  logic [15:0] replay_total, kill_total;
`endif

  always #5 clk = ~clk;

  ksa_replay_buffer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_a          (s_a),
    .s_b          (s_b),
    .s_cin        (s_cin),
    .s_vld        (s_vld),
    .s_rdy        (s_rdy),
    .m_a          (m_a),
    .m_b          (m_b),
    .m_cin        (m_cin),
    .m_vld        (m_vld),
    .m_rdy        (m_rdy),
    .res_vld      (res_vld),
    .res_rdy      (res_rdy),
    .res_mismatch (res_mismatch),
    .res_kill     (res_kill),
    .replay       (replay),
    .err          (err),
    .occupancy    (occupancy)
`ifdef KSA_REPLAY_STATS_EN
    ,
    .replay_total (replay_total),
    .kill_total   (kill_total)
`endif
  );

  int tests_run = 0;
  int tests_failed = 0;

  logic m_rdy_en, res_rdy_en, rand_mode;
  int   mm_budget, kills, replays;
  logic [16:0] src_q[$], sent_q[$], got_q[$], pipe_q[$];

  // One cycle: drive at negedge, settle, then log the handshakes that the next posedge will take
  task automatic cycle();
    logic mm;
    @(negedge clk);
    s_vld = (src_q.size() > 0) && (!rand_mode || ($urandom_range(0, 9) < 7));
    if (src_q.size() > 0) {s_a, s_b, s_cin} = src_q[0];
    m_rdy   = m_rdy_en && (!rand_mode || ($urandom_range(0, 9) < 7));
    res_rdy = res_rdy_en && (!rand_mode || ($urandom_range(0, 9) < 7));
    res_vld = (pipe_q.size() > 0);
    mm = res_vld && ((mm_budget > 0) || (rand_mode && ($urandom_range(0, 99) < 5)));
    res_mismatch = mm;
    #1;
    if (s_vld && s_rdy) sent_q.push_back(src_q.pop_front());
    if (replay) replays++;
    if (res_vld && res_rdy) begin
      if (res_kill) kills++;
      else got_q.push_back(pipe_q[0]);
      void'(pipe_q.pop_front());
      if (mm_budget > 0) mm_budget--;
    end
    if (m_vld && m_rdy) pipe_q.push_back({m_a, m_b, m_cin});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    s_vld = 1'b0; m_rdy = 1'b0; res_vld = 1'b0; res_rdy = 1'b0; res_mismatch = 1'b0;
    rand_mode = 1'b0; mm_budget = 0; kills = 0; replays = 0;
    src_q.delete(); sent_q.delete(); got_q.delete(); pipe_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    tests_run++; if (s_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_s_rdy: got %b want 1", s_rdy); end
    tests_run++; if (m_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_m_vld: got %b want 0", m_vld); end
    tests_run++; if (res_kill !== 1'b0) begin tests_failed++; $display("FAIL reset_res_kill: got %b want 0", res_kill); end
    tests_run++; if (replay !== 1'b0) begin tests_failed++; $display("FAIL reset_replay: got %b want 0", replay); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", err); end
    tests_run++; if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    rst_n = 1'b0;
  endtask

  task automatic test_single();
    int n;
    m_rdy_en = 1'b1; res_rdy_en = 1'b1; got_q.delete();
    src_q.push_back({8'h12, 8'h34, 1'b0});
    cycle();
    cycle();
    tests_run++; if (m_vld !== 1'b1) begin tests_failed++; $display("FAIL single_m_vld: got %b want 1", m_vld); end
    tests_run++; if (m_a !== 8'h12) begin tests_failed++; $display("FAIL single_m_a: got %h want 12", m_a); end
    tests_run++; if (m_b !== 8'h34) begin tests_failed++; $display("FAIL single_m_b: got %h want 34", m_b); end
    n = 0;
    while (got_q.size() < 1 && n < 20) begin cycle(); n++; end
    cycle();
    tests_run++; if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL single_occupancy: got %0d want 0", occupancy); end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== {8'h12, 8'h34, 1'b0}) begin
      tests_failed++; $display("FAIL single_commit: got %0d results want 1 of 12/34/0", got_q.size());
    end
  endtask

  task automatic test_full();
    logic [16:0] exp_q[$];
    int n;
    m_rdy_en = 1'b0; res_rdy_en = 1'b1; got_q.delete();
    for (int i = 0; i < 9; i++) exp_q.push_back({8'(8'h20 + i), 8'(8'hF0 - i), 1'(i)});
    for (int i = 0; i < 8; i++) src_q.push_back(exp_q[i]);
    n = 0;
    while (src_q.size() > 0 && n < 30) begin cycle(); n++; end
    src_q.push_back(exp_q[8]);
    cycle();
    tests_run++; if (s_rdy !== 1'b0) begin tests_failed++; $display("FAIL full_s_rdy: got %b want 0", s_rdy); end
    tests_run++; if (occupancy !== 4'd8) begin tests_failed++; $display("FAIL full_occupancy: got %0d want 8", occupancy); end
    m_rdy_en = 1'b1;
    n = 0;
    while (got_q.size() < 1 && n < 20) begin cycle(); n++; end
    tests_run++; if (s_rdy !== 1'b0) begin tests_failed++; $display("FAIL full_commit_cycle_s_rdy: got %b want 0", s_rdy); end
    cycle();
    tests_run++; if (s_rdy !== 1'b1) begin tests_failed++; $display("FAIL full_after_commit_s_rdy: got %b want 1", s_rdy); end
    tests_run++; if (occupancy !== 4'd7) begin tests_failed++; $display("FAIL full_after_commit_occ: got %0d want 7", occupancy); end
    n = 0;
    while (got_q.size() < 9 && n < 80) begin cycle(); n++; end
    for (int i = 0; i < 9; i++) begin
      tests_run++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL full_order[%0d]: got %0d results want entry %h", i, got_q.size(), exp_q[i]);
      end
    end
  endtask

  task automatic test_replay();
    logic [16:0] exp_q[$];
    int n;
    m_rdy_en = 1'b1; res_rdy_en = 1'b0; got_q.delete(); kills = 0; replays = 0;
    exp_q.push_back({8'h01, 8'h10, 1'b0});
    exp_q.push_back({8'h02, 8'h20, 1'b1});
    exp_q.push_back({8'h03, 8'h30, 1'b0});
    foreach (exp_q[i]) src_q.push_back(exp_q[i]);
    n = 0;
    while (pipe_q.size() < 3 && n < 20) begin cycle(); n++; end
    res_rdy_en = 1'b1; mm_budget = 1;
    cycle();
    tests_run++; if (res_kill !== 1'b1) begin tests_failed++; $display("FAIL replay_first_kill: got %b want 1", res_kill); end
    cycle();
    tests_run++; if (m_vld !== 1'b0) begin tests_failed++; $display("FAIL replay_drain_m_vld: got %b want 0", m_vld); end
    n = 0;
    while (got_q.size() < 3 && n < 40) begin cycle(); n++; end
    tests_run++; if (kills != 3) begin tests_failed++; $display("FAIL replay_kills: got %0d want 3", kills); end
    tests_run++; if (replays != 1) begin tests_failed++; $display("FAIL replay_pulses: got %0d want 1", replays); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        tests_failed++; $display("FAIL replay_order[%0d]: got %0d results want entry %h", i, got_q.size(), exp_q[i]);
      end
    end
  endtask

  task automatic test_retry_limit();
    int n;
    m_rdy_en = 1'b1; res_rdy_en = 1'b1; got_q.delete(); kills = 0; replays = 0;
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL retry_err_before: got %b want 0", err); end
    src_q.push_back({8'hA5, 8'h5A, 1'b1});
    mm_budget = 4;
    n = 0;
    while (got_q.size() < 1 && n < 60) begin cycle(); n++; end
    cycle();
    tests_run++; if (replays != 3) begin tests_failed++; $display("FAIL retry_replays: got %0d want 3", replays); end
    tests_run++; if (kills != 3) begin tests_failed++; $display("FAIL retry_kills: got %0d want 3", kills); end
    tests_run++;
    if (got_q.size() != 1 || got_q[0] !== {8'hA5, 8'h5A, 1'b1}) begin
      tests_failed++; $display("FAIL retry_commit: got %0d results want 1 of A5/5A/1", got_q.size());
    end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL retry_err_set: got %b want 1", err); end
    src_q.push_back({8'h11, 8'h22, 1'b0});
    n = 0;
    while (got_q.size() < 2 && n < 20) begin cycle(); n++; end
    cycle(); cycle();
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("FAIL retry_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_random();
    localparam int NOPS = 1500;
    int n, bad;
    do_reset();
    rand_mode = 1'b1; m_rdy_en = 1'b1; res_rdy_en = 1'b1;
    for (int i = 0; i < NOPS; i++) src_q.push_back(17'($urandom));
    n = 0;
    while (got_q.size() < NOPS && n < 40000) begin cycle(); n++; end
    rand_mode = 1'b0;
    tests_run++; if (got_q.size() != NOPS) begin tests_failed++; $display("FAIL random_count: got %0d want %0d", got_q.size(), NOPS); end
    bad = 0;
    for (int i = 0; i < NOPS && i < got_q.size() && i < sent_q.size(); i++) begin
      if (got_q[i] !== sent_q[i]) bad++;
    end
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL random_order: got %0d misordered want 0", bad); end
    tests_run++; if (replays == 0) begin tests_failed++; $display("FAIL random_replays: got 0 want nonzero"); end
  endtask

  task automatic test_reset_mid();
    int n;
    m_rdy_en = 1'b0; res_rdy_en = 1'b1;
    for (int i = 0; i < 5; i++) src_q.push_back({8'(i), 8'(i + 1), 1'b1});
    n = 0;
    while (src_q.size() > 0 && n < 20) begin cycle(); n++; end
    cycle();
    tests_run++; if (occupancy !== 4'd5) begin tests_failed++; $display("FAIL midrst_pre_occ: got %0d want 5", occupancy); end
    rst_n = 1'b1;
    s_vld = 1'b0; res_vld = 1'b0; pipe_q.delete();
    @(posedge clk);
    #1;
    tests_run++; if (occupancy !== 4'd0) begin tests_failed++; $display("FAIL midrst_occ: got %0d want 0", occupancy); end
    tests_run++; if (m_vld !== 1'b0) begin tests_failed++; $display("FAIL midrst_m_vld: got %b want 0", m_vld); end
    tests_run++; if (s_rdy !== 1'b1) begin tests_failed++; $display("FAIL midrst_s_rdy: got %b want 1", s_rdy); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("FAIL midrst_err: got %b want 0", err); end
    @(negedge clk);
    rst_n = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    s_a = '0; s_b = '0; s_cin = 1'b0; s_vld = 1'b0; m_rdy = 1'b0;
    res_vld = 1'b0; res_rdy = 1'b0; res_mismatch = 1'b0;
    m_rdy_en = 1'b0; res_rdy_en = 1'b0; rand_mode = 1'b0;
    mm_budget = 0; kills = 0; replays = 0;
    test_reset();
    test_single();
    test_full();
    test_replay();
    test_retry_limit();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
